// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: serial stream input and lock/error status bundle for lfsr_checker.
interface lfsr_checker_if;
  logic in_valid;
  logic in_bit;
  logic locked;
  logic bit_err;
  logic sync_lost;
  logic [31:0] err_count;
  modport master(output in_valid, in_bit, input locked, bit_err, sync_lost, err_count);
  modport slave(input in_valid, in_bit, output locked, bit_err, sync_lost, err_count);
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising XNOR Fibonacci LFSR stream checker with flywheel and error count.
// Define LFSR_CHK_RESYNC_EN to drop lock after LOSS_LIMIT mismatches; otherwise LOCKED is terminal.
module lfsr_checker #(
  parameter int WIDTH      = 64,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  lfsr_checker_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int T1 = WIDTH == 8 ? 5 : WIDTH == 16 ? 14 : 62;
  localparam int T2 = WIDTH == 8 ? 4 : WIDTH == 16 ? 12 : 60;
  localparam int T3 = WIDTH == 8 ? 3 : WIDTH == 16 ? 3 : 59;
  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 64) || LOCK_COUNT < 1 || LOCK_COUNT > 255 ||
      LOSS_LIMIT < 1 || LOSS_LIMIT > 255) begin : g_bad_cfg
    $error("lfsr_checker: illegal parameter set");
  end
  typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_in;
  logic [CW-1:0]    fill_cnt;
  logic [7:0]       run_cnt;
  logic             locked;
  logic             bit_err;
  logic             sync_lost;
  logic [31:0]      err_count;
  logic             pred;
  logic             match;
`ifdef LFSR_CHK_RESYNC_EN
  logic [7:0]       miss_cnt;
  logic [7:0]       good_run;
`endif
  assign pred          = ~(sr[WIDTH-1] ^ sr[T1] ^ sr[T2] ^ sr[T3]);
  assign match         = bus.in_bit == pred;
  assign sr_in         = {sr[WIDTH-2:0], bus.in_bit};
  assign bus.locked    = locked;
  assign bus.bit_err   = bit_err;
  assign bus.sync_lost = sync_lost;
  assign bus.err_count = err_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      sr        <= '0;
      fill_cnt  <= '0;
      run_cnt   <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      sync_lost <= 1'b0;
      err_count <= '0;
`ifdef LFSR_CHK_RESYNC_EN
      miss_cnt  <= '0;
      good_run  <= '0;
`endif
    end else begin
      bit_err   <= 1'b0;
      sync_lost <= 1'b0;
      if (bus.in_valid)
        case (state)
          FILL: begin
            sr       <= sr_in;
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_cnt == CW'(WIDTH - 1)) begin
              fill_cnt <= '0;
              run_cnt  <= '0;
              if (!(&sr_in)) state <= VERIFY;
            end
          end
          VERIFY: begin
            sr      <= sr_in;
            run_cnt <= run_cnt + 1'b1;
            if (!match) begin
              state    <= FILL;
              fill_cnt <= '0;
            end else if (run_cnt == 8'(LOCK_COUNT - 1)) begin
              state  <= LOCKED;
              locked <= 1'b1;
`ifdef LFSR_CHK_RESYNC_EN
              miss_cnt <= '0;
              good_run <= '0;
`endif
            end
          end
          default: begin
            // flywheel: the prediction, not the received bit, feeds the register
            sr <= {sr[WIDTH-2:0], pred};
            if (!match) begin
              bit_err   <= 1'b1;
              err_count <= err_count + {31'd0, ~&err_count};
`ifdef LFSR_CHK_RESYNC_EN
              miss_cnt  <= miss_cnt + 1'b1;
              good_run  <= '0;
              if (miss_cnt == 8'(LOSS_LIMIT - 1)) begin
                sync_lost <= 1'b1;
                locked    <= 1'b0;
                state     <= FILL;
                fill_cnt  <= '0;
              end
            end else begin
              good_run <= good_run + 1'b1;
              if (good_run == 8'(LOCK_COUNT - 1)) begin
                miss_cnt <= '0;
                good_run <= '0;
              end
`endif
            end
          end
        endcase
    end
  end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table-driven error-injection scenarios plus randomized stream checked against a history-queue model.
module tb_lfsr_checker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  lfsr_checker_if bus();
  lfsr_checker #(.WIDTH(64), .LOCK_COUNT(16), .LOSS_LIMIT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
`ifdef LFSR_CHK_RESYNC_EN
  localparam bit RES = 1'b1;
`else
  localparam bit RES = 1'b0;
`endif
  typedef struct {
    int n_err;
    int gap;
    bit exp_locked;
    int exp_err;
    int exp_sync;
  } row_t;
  int checks = 0;
  int errors = 0;
  logic [63:0] g;
  int vbits, lock_at, pulses, syncs, base;
  bit q[$];
  int ph, fills, run, miss, good;
  bit m_lock, m_berr, m_sync;
  logic [31:0] m_err;
  function automatic bit gen();
    bit nb;
    nb = ~(g[63] ^ g[62] ^ g[60] ^ g[59]);
    g = {g[62:0], nb};
    return nb;
  endfunction
  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (valid bit %0d)", name, got, exp, vbits);
    end
  endtask
  task automatic model_reset();
    q.delete();
    ph = 0; fills = 0; run = 0; miss = 0; good = 0;
    m_lock = 0; m_berr = 0; m_sync = 0; m_err = '0;
    vbits = 0; lock_at = -1; pulses = 0; syncs = 0;
  endtask
  task automatic push(bit x);
    q.push_back(x);
    if (q.size() > 64) void'(q.pop_front());
  endtask
  // Reference: predicted bit is XNOR of the reference history 64,63,61,60 bits back.
  task automatic model_step(bit v, bit b);
    bit p;
    int n, ones;
    m_berr = 0;
    m_sync = 0;
    if (!v) return;
    vbits++;
    n = q.size();
    p = n >= 64 ? ~(q[n-64] ^ q[n-63] ^ q[n-61] ^ q[n-60]) : 1'b0;
    if (ph == 0) begin
      push(b);
      fills++;
      if (fills == 64) begin
        fills = 0;
        ones = 0;
        foreach (q[i]) ones += int'(q[i]);
        if (ones != 64) begin ph = 1; run = 0; end
      end
    end else if (ph == 1) begin
      push(b);
      if (b == p) begin
        run++;
        if (run == 16) begin ph = 2; m_lock = 1; miss = 0; good = 0; end
      end else begin
        ph = 0; fills = 0;
      end
    end else begin
      push(p);
      if (b != p) begin
        m_berr = 1;
        if (m_err != 32'hFFFF_FFFF) m_err++;
        miss++;
        good = 0;
        if (RES && miss == 8) begin m_sync = 1; m_lock = 0; ph = 0; fills = 0; end
      end else begin
        good++;
        if (good == 16) begin miss = 0; good = 0; end
      end
    end
  endtask
  task automatic drive(bit v, bit b);
    bus.in_valid = v;
    bus.in_bit   = b;
    @(posedge clk);
    #1;
    model_step(v, b);
    check("outputs{locked,bit_err,sync_lost,err_count}",
          {29'd0, bus.locked, bus.bit_err, bus.sync_lost, bus.err_count},
          {29'd0, m_lock, m_berr, m_sync, m_err});
    if (bus.bit_err) pulses++;
    if (bus.sync_lost) syncs++;
    if (bus.locked && lock_at < 0) lock_at = vbits;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'($urandom);
    bus.in_bit   = 1'($urandom);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    check("reset_outputs", {29'd0, bus.locked, bus.bit_err, bus.sync_lost, bus.err_count}, 64'd0);
  endtask
  task automatic clean(int n);
    repeat (n) drive(1'b1, gen());
  endtask
  initial begin
    row_t rows[3];
    bit v;
    int cyc;
    rows[0] = '{n_err: 1, gap: 1, exp_locked: 1'b1, exp_err: 1, exp_sync: 0};
    rows[1] = '{n_err: 8, gap: 4, exp_locked: !RES, exp_err: 8, exp_sync: int'(RES)};
    rows[2] = '{n_err: 3, gap: 1, exp_locked: 1'b1, exp_err: 3, exp_sync: 0};
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset();
    g = 64'h1;
    clean(10000);
    check("clean_lock_latency", 64'(lock_at), 64'd80);
    check("clean_locked", {63'd0, bus.locked}, 64'd1);
    check("clean_err_count", {32'd0, bus.err_count}, 64'd0);
    check("clean_bit_err_pulses", 64'(pulses), 64'd0);
    foreach (rows[r]) begin
      do_reset();
      g = 64'h1;
      clean(199);
      for (int e = 0; e < rows[r].n_err; e++) begin
        drive(1'b1, ~gen());
        if (e < rows[r].n_err - 1) clean(rows[r].gap - 1);
      end
      check("inj_pulses", 64'(pulses), 64'(rows[r].n_err));
      check("inj_sync_lost", 64'(syncs), 64'(rows[r].exp_sync));
      check("inj_locked", {63'd0, bus.locked}, {63'd0, rows[r].exp_locked});
      check("inj_err_count", {32'd0, bus.err_count}, 64'(rows[r].exp_err));
      base = vbits;
      lock_at = -1;
      clean(80);
      check("post_locked", {63'd0, bus.locked}, 64'd1);
      check("post_err_count", {32'd0, bus.err_count}, 64'(rows[r].exp_err));
      check("post_pulses", 64'(pulses), 64'(rows[r].n_err));
      if (rows[r].exp_sync != 0) check("relock_latency", 64'(lock_at - base), 64'd80);
    end
    do_reset();
    repeat (64) drive(1'b1, 1'b1);
    check("lockup_locked", {63'd0, bus.locked}, 64'd0);
    g = 64'h1;
    lock_at = -1;
    base = vbits;
    clean(80);
    check("lockup_relock_latency", 64'(lock_at - base), 64'd80);
    do_reset();
    g = 64'h1;
    clean(68);
    drive(1'b1, ~gen());
    clean(80);
    check("verify_miss_lock_at", 64'(lock_at), 64'd149);
    check("verify_miss_err_count", {32'd0, bus.err_count}, 64'd0);
    do_reset();
    g = 64'h1;
    cyc = 0;
    while (vbits < 70 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      drive(v, v ? gen() : 1'($urandom));
      cyc++;
    end
    check("random_reached_70", 64'(vbits), 64'd70);
    do_reset();
    cyc = 0;
    while (vbits < 80 && cyc < 2000) begin
      v = 1'($urandom_range(0, 1));
      drive(v, v ? gen() : 1'($urandom));
      cyc++;
    end
    check("random_lock_at", 64'(lock_at), 64'd80);
    check("random_pulses", 64'(pulses), 64'd0);
    do_reset();
    g = 64'h1;
    repeat (4000) begin
      v = 1'($urandom_range(0, 1));
      drive(v, v ? (gen() ^ ($urandom_range(0, 63) == 0)) : 1'($urandom));
    end
    check("random_err_total", {32'd0, bus.err_count}, {32'd0, m_err});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
